// File: rtl/sha1_padder.sv
// sha1_padder: SHA-1 message padder turning a byte stream into 512-bit blocks in message_in word order.
module sha1_padder #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  input  logic         byte_last,
  output logic         byte_ready,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_final,
  output logic         len_overflow
);
  typedef enum logic [1:0] {FILL, PAD, EMIT, EMIT2} state_t;
  typedef enum logic [1:0] {NONE, LEN0, LEN80} pend_t;
  state_t state, state_nx;
  pend_t pend;
  logic [6:0] pos;
  logic [CNT_W-1:0] count;
  logic live;
  logic [63:0] bit_len;
  logic [511:0] pad_blk;
  logic byte_xfer, block_xfer;
  assign byte_ready = live & (state == FILL);
  assign block_valid = (state == EMIT) | (state == EMIT2);
  assign byte_xfer = byte_valid & byte_ready;
  assign block_xfer = block_valid & block_ready;
  assign bit_len = 64'(count) << 3;
  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:  if (byte_xfer) state_nx = byte_last ? PAD : pos == 7'd63 ? EMIT : FILL;
      PAD:   state_nx = EMIT;
      EMIT:  if (block_xfer) state_nx = pend == NONE ? FILL : EMIT2;
      EMIT2: if (block_xfer) state_nx = FILL;
    endcase
  end
  // pos holds n (1..64); bytes past the 0x80 marker are scrubbed of any earlier message
  always_comb begin
    pad_blk = block_out;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) == pos) pad_blk[32*(i/4) + 8*(3-i%4) +: 8] = 8'h80;
      else if (7'(i) > pos && (pos > 7'd55 || i < 56)) pad_blk[32*(i/4) + 8*(3-i%4) +: 8] = 8'h00;
    end
    if (pos <= 7'd55) pad_blk[511:448] = {bit_len[31:0], bit_len[63:32]};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FILL;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos <= '0;
      count <= '0;
      block_out <= '0;
      block_final <= 1'b0;
      len_overflow <= 1'b0;
      pend <= NONE;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        FILL: if (byte_xfer) begin
          block_out[{pos[5:2], ~pos[1:0], 3'b000} +: 8] <= byte_in;
          count <= count + CNT_W'(1);
          if (&count) len_overflow <= 1'b1;
          pos <= (pos == 7'd63 && !byte_last) ? 7'd0 : pos + 7'd1;
          block_final <= 1'b0;
        end
        PAD: begin
          block_out <= pad_blk;
          block_final <= pos <= 7'd55;
          pend <= pos == 7'd64 ? LEN80 : pos >= 7'd56 ? LEN0 : NONE;
          pos <= '0;
        end
        EMIT: if (block_xfer) begin
          if (pend != NONE) begin
            block_out <= {bit_len[31:0], bit_len[63:32], 416'd0, pend == LEN80 ? 32'h8000_0000 : 32'd0};
            block_final <= 1'b1;
          end else if (block_final) begin
            count <= '0;
            len_overflow <= 1'b0;
            block_final <= 1'b0;
          end
        end
        EMIT2: if (block_xfer) begin
          count <= '0;
          len_overflow <= 1'b0;
          pend <= NONE;
          block_final <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/sha1_padder.md
Name: sha1_padder

Overview:
- Front-end message formatter for the sha1 core; feeds it 512-bit blocks.
- Accepts a message as a byte stream over a valid/ready handshake.
- Applies SHA-1 padding: a 0x80 byte, zero fill, then the 64-bit big-endian message bit length.
- Emits one or more 512-bit blocks over a valid/ready handshake, packed in the core's message_in word order. The last block of a message is flagged.

Parameters:
CNT_W, 32, width of the internal byte counter; bit length = {zero-extend to 61 bits, count} concatenated with 3'b000. Must be 8..61.

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  asynchronous, active-low reset
byte_in  input  8  message byte, stream order
byte_valid  input  1  byte_in valid
byte_last  input  1  qualifies the final byte of the message (sampled with byte_valid)
byte_ready  output  1  padder can accept a byte this cycle
block_out  output  512  formatted block; word j at [32j+31:32j], W[0] at [31:0], W[15] at [511:480]; each word big-endian (first stream byte in bits [31:24])
block_valid  output  1  block_out holds a block
block_ready  input  1  consumer takes the block
block_final  output  1  valid with block_valid; this block ends the message
len_overflow  output  1  sticky; byte counter wrapped during the current message

Behaviour:
- Reset is one clock domain, asynchronous assert, active-low. During reset and after it deasserts:
  - state=FILL, pos=0, count=0
  - block_out=0, block_valid=0, block_final=0, len_overflow=0
  - byte_ready=1 from the first clock edge after release.
- A byte transfer occurs on byte_valid & byte_ready. A block transfer occurs on block_valid & block_ready.
- byte_ready=1 only in FILL. block_valid=1 only in EMIT and EMIT2.
- FILL:
  - On a byte transfer, write byte_in at byte position pos (0..63) and increment pos and count.
  - count increments wrap at 2^CNT_W; a wrap sets len_overflow.
  - Non-last byte with pos==63: block complete; go to EMIT with block_final=0 and pos cleared.
  - Last byte: go to PAD. Let n = pos+1, 1..64.
- PAD (exactly 1 cycle, byte_ready=0). Builds the block registers:
  - n<=55: byte n=0x80; bytes n+1..55=0; bytes 56..63=bit length; block_final=1. Go to EMIT, with no second block pending.
  - 56<=n<=63: byte n=0x80; bytes n+1..63=0; block_final=0. Set pend=LEN0. Go to EMIT.
  - n==64: buffer unchanged; block_final=0. Set pend=LEN80. Go to EMIT.
- EMIT:
  - block_out and block_final are held stable while block_valid=1 and block_ready=0.
  - On transfer with no pend: if block_final, clear count and len_overflow; go to FILL.
  - On transfer with pend set: go to EMIT2 the next cycle. The second block is loaded in the same edge:
    - LEN80: word0=0x80000000, words1..13=0.
    - LEN0: words0..13=0.
    - Both: words14..15 = bit length (word14 = high 32 bits, word15 = low 32 bits); block_final=1.
- EMIT2: identical to EMIT; on transfer, clear count, len_overflow and pend; go to FILL.
- Latency:
  - Last byte accepted at edge t gives block_valid at edge t+2.
  - A full non-last block accepted at edge t gives block_valid at edge t+1.
- block_valid drops on the edge of the block transfer. The next byte can be accepted the cycle after.
- Bit length is computed from count after the last byte has been counted.
- Zero-length messages are not supported; a message is at least one byte.
- Reset asserted mid-message or mid-handshake: everything cleared immediately; any partial block is discarded; block_valid=0 asynchronously.
- byte_valid while byte_ready=0 is ignored; byte_in is not sampled.
- byte_last while in a non-FILL state has no effect.

Test Plan:
- "abc" (0x61,0x62,0x63 with byte_last on 0x63), block_ready=1 -> one block, block_final=1:
  - word0=0x61626380, words1..14=0, word15=0x00000018
  - block_valid rises 2 cycles after the last byte.
- 55 bytes of 0x00 -> one final block:
  - byte55=0x80, so word13=0x00000080
  - word14=0, word15=0x000001B8.
- 56 bytes of 0xFF -> two blocks:
  - first (block_final=0): words0..13=0xFFFFFFFF, word14=0x80000000, word15=0
  - second (block_final=1): words0..14=0, word15=0x000001C0.
- 64 bytes 0x00..0x3F -> two blocks:
  - first: word0=0x00010203, word15=0x3C3D3E3F, final=0
  - second: word0=0x80000000, word15=0x00000200, final=1.
- Backpressure: hold block_ready=0 for 10 cycles on the "abc" block -> block_valid stays 1, block_out stable, byte_ready=0. Release -> transfer, byte_ready=1 next cycle.
- Assert reset during EMIT of the first 56-byte block -> block_valid=0 immediately. After release, byte_ready=1 and "abc" yields the exact "abc" block above.
